vram_arbiter: RTL

//  Shares one single-port synchronous video RAM between the VGA display

---
 rtl/vram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads own every visible pixel tick, one writer uses the free cycles.
// Optional macro VRAM_ARB_BLANK_ONLY_EN restricts writes to vertical blanking (tear-free updates).
module vram_arbiter #(
  parameter int DW          = 8,
  parameter int AW          = 19,
  parameter int SCALE_SHIFT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          video_on_out
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } wr_state_t;

  localparam logic [AW-1:0] H_RES = AW'(640 >> SCALE_SHIFT);

  wr_state_t     state, state_next;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [9:0]    x_s, y_s;
  logic [AW-1:0] fb_addr;
  logic          rd_slot, wr_slot, wr_fire;
  logic          rd_q;
  logic [DW-1:0] pix_q;
  logic [1:0]    hs_pipe, vs_pipe, von_pipe;

  assign x_s     = pixel_x >> SCALE_SHIFT;
  assign y_s     = pixel_y >> SCALE_SHIFT;
  assign fb_addr = AW'(y_s) * H_RES + AW'(x_s);

  assign rd_slot = p_tick & video_on;
`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign wr_slot = ~rd_slot & (pixel_y >= 10'd480);
`else
  assign wr_slot = ~rd_slot;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && wr_req) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
    end
  end

  // The display read always wins a contested cycle; the write simply waits in PEND.
  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    wr_ack     = 1'b0;
    case (state)
      IDLE: if (wr_req) state_next = PEND;
      PEND: begin
        if (wr_slot) begin
          wr_fire    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        wr_ack     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_busy   = (state != IDLE);
  assign mem_we    = wr_fire;
  assign mem_addr  = wr_fire ? wr_addr_q : fb_addr;
  assign mem_wdata = wr_data_q;

  // Two stages on syncs match the read pipe: address in N, data back in N+1, on pix_out from N+2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q     <= 1'b0;
      pix_q    <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      von_pipe <= '0;
    end else begin
      rd_q     <= rd_slot;
      if (rd_q) pix_q <= mem_rdata;
      hs_pipe  <= {hs_pipe[0], hsync_in};
      vs_pipe  <= {vs_pipe[0], vsync_in};
      von_pipe <= {von_pipe[0], video_on};
    end
  end

  assign hsync_out    = hs_pipe[1];
  assign vsync_out    = vs_pipe[1];
  assign video_on_out = von_pipe[1];
  assign pix_out      = video_on_out ? pix_q : '0;

endmodule
